ov7670_cfg_seq: RTL

- Upstream control stage for the OV7670 camera wrapper.
- Walks a constant register table and issues one I2C write per entry through the wrapper's i2c_start_en / i2c_addr_i / i2c_data_i / delay_i / i2c_ready_o handshake.
- After the last write and a settle interval, fires a single pxl_start_en pulse so pixel capture and binning begin on a correctly configured sensor.
- Reports busy, done and timeout status to the top-level controller.

---
 rtl/ov7670_cfg_pkg.sv | 98 +++++++++
 rtl/ov7670_cfg_seq.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ov7670_cfg_pkg.sv
// OV7670 configuration sequencer: shared types, states and register table.
// Entry 0 soft-resets the sensor; the rest set up RGB565 QVGA output.
package ov7670_cfg_pkg;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] delay;
  } cfg_entry_t;

  localparam int CFG_ROM_DEPTH = 64;
  localparam int IDX_W = $clog2(CFG_ROM_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    ISSUE,
    WAIT_ACK,
    WAIT_FIN,
    NEXT,
    SETTLE,
    START_PXL,
    DONE,
    ERR
  } cfg_state_t;

  localparam logic [31:0] RST_DLY = 32'd1_000_000;
  localparam logic [31:0] WR_DLY  = 32'd1_000;

  localparam cfg_entry_t CFG_ROM [CFG_ROM_DEPTH] = '{
    '{8'h12, 8'h80, RST_DLY},
    '{8'h12, 8'h14, WR_DLY},
    '{8'h40, 8'hD0, WR_DLY},
    '{8'h11, 8'h01, WR_DLY},
    '{8'h0C, 8'h04, WR_DLY},
    '{8'h3E, 8'h19, WR_DLY},
    '{8'h70, 8'h3A, WR_DLY},
    '{8'h71, 8'h35, WR_DLY},
    '{8'h72, 8'h11, WR_DLY},
    '{8'h73, 8'hF1, WR_DLY},
    '{8'hA2, 8'h02, WR_DLY},
    '{8'h8C, 8'h00, WR_DLY},
    '{8'h04, 8'h00, WR_DLY},
    '{8'h14, 8'h38, WR_DLY},
    '{8'h4F, 8'hB3, WR_DLY},
    '{8'h50, 8'hB3, WR_DLY},
    '{8'h51, 8'h00, WR_DLY},
    '{8'h52, 8'h3D, WR_DLY},
    '{8'h53, 8'hA7, WR_DLY},
    '{8'h54, 8'hE4, WR_DLY},
    '{8'h58, 8'h9E, WR_DLY},
    '{8'h3D, 8'hC0, WR_DLY},
    '{8'h17, 8'h16, WR_DLY},
    '{8'h18, 8'h04, WR_DLY},
    '{8'h32, 8'h24, WR_DLY},
    '{8'h19, 8'h02, WR_DLY},
    '{8'h1A, 8'h7A, WR_DLY},
    '{8'h03, 8'h0A, WR_DLY},
    '{8'h0F, 8'h41, WR_DLY},
    '{8'h1E, 8'h00, WR_DLY},
    '{8'h33, 8'h0B, WR_DLY},
    '{8'h3C, 8'h78, WR_DLY},
    '{8'h69, 8'h00, WR_DLY},
    '{8'h74, 8'h00, WR_DLY},
    '{8'hB0, 8'h84, WR_DLY},
    '{8'hB1, 8'h0C, WR_DLY},
    '{8'hB2, 8'h0E, WR_DLY},
    '{8'hB3, 8'h80, WR_DLY},
    '{8'h7A, 8'h20, WR_DLY},
    '{8'h7B, 8'h10, WR_DLY},
    '{8'h7C, 8'h1E, WR_DLY},
    '{8'h7D, 8'h35, WR_DLY},
    '{8'h7E, 8'h5A, WR_DLY},
    '{8'h7F, 8'h69, WR_DLY},
    '{8'h80, 8'h76, WR_DLY},
    '{8'h81, 8'h80, WR_DLY},
    '{8'h82, 8'h88, WR_DLY},
    '{8'h83, 8'h8F, WR_DLY},
    '{8'h84, 8'h96, WR_DLY},
    '{8'h85, 8'hA3, WR_DLY},
    '{8'h86, 8'hAF, WR_DLY},
    '{8'h87, 8'hC4, WR_DLY},
    '{8'h88, 8'hD7, WR_DLY},
    '{8'h89, 8'hE8, WR_DLY},
    '{8'h13, 8'hE0, WR_DLY},
    '{8'h00, 8'h00, WR_DLY},
    '{8'h10, 8'h00, WR_DLY},
    '{8'h0D, 8'h40, WR_DLY},
    '{8'h14, 8'h18, WR_DLY},
    '{8'hA5, 8'h05, WR_DLY},
    '{8'hAB, 8'h07, WR_DLY},
    '{8'h24, 8'h95, WR_DLY},
    '{8'h25, 8'h33, WR_DLY},
    '{8'h13, 8'hE7, WR_DLY}
  };

endpackage

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 register table through the I2C wrapper handshake,
// then waits a settle interval and fires one pixel-capture start pulse.
module ov7670_cfg_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int NUM_REGS      = 64,
  parameter int SETTLE_CYCLES = 30_000_000,
  parameter int ACK_TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_start_i,
  input  logic        i2c_ready_i,
  output logic        i2c_start_en_o,
  output logic [7:0]  i2c_addr_o,
  output logic [7:0]  i2c_data_o,
  output logic [31:0] delay_o,
  output logic        pxl_start_en_o,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic [5:0]  reg_idx_o
);

  localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] SET_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  cfg_state_t       state;
  cfg_state_t       state_n;
  logic [IDX_W-1:0] idx;
  logic [31:0]      tmo_cnt;
  logic [31:0]      set_cnt;
  cfg_entry_t       ent;
  logic             waiting;
  logic             tmo_hit;
  logic             entering;

  assign waiting = (state == WAIT_RDY) ||
                   (state == WAIT_ACK) ||
                   (state == WAIT_FIN);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign entering = (state_n != state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    i2c_start_en_o = 1'b0;
    pxl_start_en_o = 1'b0;
    cfg_busy_o     = 1'b1;
    cfg_done_o     = 1'b0;
    cfg_err_o      = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        cfg_busy_o = 1'b0;
        cfg_done_o = (state == DONE);
        cfg_err_o  = (state == ERR);
        if (cfg_start_i) state_n = LOAD;
      end
      LOAD: state_n = WAIT_RDY;
      WAIT_RDY: begin
        if (i2c_ready_i) state_n = ISSUE;
        else if (tmo_hit) state_n = ERR;
      end
      ISSUE: begin
        i2c_start_en_o = 1'b1;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!i2c_ready_i) state_n = WAIT_FIN;
        else if (tmo_hit) state_n = ERR;
      end
      WAIT_FIN: begin
        if (i2c_ready_i) state_n = NEXT;
        else if (tmo_hit) state_n = ERR;
      end
      NEXT: begin
        if (idx != IDX_LAST) state_n = LOAD;
        else if (SETTLE_CYCLES == 0) state_n = START_PXL;
        else state_n = SETTLE;
      end
      SETTLE: begin
        if (set_cnt == SET_LAST) state_n = START_PXL;
      end
      START_PXL: begin
        pxl_start_en_o = 1'b1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Both counters restart on every state change and saturate, never wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
      set_cnt <= '0;
    end else begin
      if (entering) tmo_cnt <= '0;
      else if (waiting && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
      if (entering) set_cnt <= '0;
      else if (state == SETTLE && set_cnt != '1)
        set_cnt <= set_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx <= '0;
      ent <= '0;
    end else begin
      if (state_n == LOAD && state != NEXT) idx <= '0;
      else if (state == NEXT && idx != IDX_LAST) idx <= idx + 1'b1;
      if (state == LOAD) ent <= CFG_ROM[idx];
    end
  end

  assign i2c_addr_o = ent.addr;
  assign i2c_data_o = ent.data;
  assign delay_o    = ent.delay;
  assign reg_idx_o  = 6'(idx);

endmodule
